si_bullet_shifter_bank: RTL

Parametrised bank of NUM_CH independent bullet-track shift registers for the Space Invaders playfield. Each channel is one screen column of DEPTH cells.
- A shared prescaler advances every track by one cell per tick.
- Bullets are injected at the entry cell and removed on collision (kill) or on leaving the track (escape).
- Sits between the fire/collision logic and the video/collision matrix. It supersedes the single-register load/clear bullet register.

---
 rtl/si_bullet_pkg.sv | 36 +++
 rtl/si_bullet_track.sv | 106 ++++++++++
 rtl/si_bullet_shifter_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/si_bullet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : si_bullet_pkg
//  Description : Shared constants and elaboration-time helper functions for
//                the Space Invaders bullet shifter bank.
//                - SI_DIR_UP / SI_DIR_DOWN : track direction encodings
//                - siEndIdx()   : entry or exit cell index of a track
//                - siCntWidth() : prescaler counter width for a tick divider
//  Revision    : 1.0  - initial release
// ============================================================================
package si_bullet_pkg;

    // Track direction encodings.
    // Up   : entry = bit 0, bullets move toward the MSB, exit = MSB.
    // Down : entry = MSB, bullets move toward bit 0, exit = bit 0.
    localparam logic SI_DIR_UP   = 1'b1;
    localparam logic SI_DIR_DOWN = 1'b0;

    // Index of the entry cell (wantExit = 0) or the exit cell (wantExit = 1)
    // of a track of the given depth and direction.
    function automatic int siEndIdx(input int depth, input logic dirUp, input logic wantExit);
        logic atMsb;
        // The entry sits at the MSB only for downward tracks; the exit is
        // always the opposite end.
        atMsb = (dirUp == SI_DIR_UP) ? wantExit : ~wantExit;
        return atMsb ? (depth - 1) : 0;
    endfunction

    // Prescaler counter width, max(1, clog2(tickDiv)). A divider of 1 still
    // needs a one-bit counter so that the compare logic stays uniform.
    function automatic int siCntWidth(input int tickDiv);
        return (tickDiv <= 2) ? 1 : $clog2(tickDiv);
    endfunction

endpackage : si_bullet_pkg
`default_nettype wire

// File: rtl/si_bullet_track.sv
`default_nettype none
// ============================================================================
//  Module      : si_bullet_track
//  Description : One bullet track (one playfield column) of DEPTH cells.
//                Each cycle the next contents are built in this order:
//                  1. optional shift one cell toward the exit (on tick),
//                     the bullet leaving the exit cell is reported as escape
//                  2. kill mask removes bullets at post-shift positions
//                  3. fire places a bullet in the entry cell if it is free
//                Clear wipes the track and suppresses ack/escape.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-high reset
//                i_clear    - synchronous clear of track, ack and escape
//                i_tick     - apply a shift at the next edge
//                i_fire     - bullet injection request (level)
//                i_kill     - per-cell removal mask
//                o_data     - registered track contents
//                o_fireAck  - registered pulse, fire accepted last cycle
//                o_escape   - registered pulse, bullet shifted out last cycle
//  Revision    : 1.0  - initial release
// ============================================================================
module si_bullet_track
    import si_bullet_pkg::*;
#(
    parameter int   DEPTH  = 8,
    parameter logic DIR_UP = SI_DIR_UP
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic             i_fire,
    input  logic [DEPTH-1:0] i_kill,
    output logic [DEPTH-1:0] o_data,
    output logic             o_fireAck,
    output logic             o_escape
);

    localparam int c_ENTRY = siEndIdx(DEPTH, DIR_UP, 1'b0);
    localparam int c_EXIT  = siEndIdx(DEPTH, DIR_UP, 1'b1);

    logic [DEPTH-1:0] r_track;
    logic             r_fireAck;
    logic             r_escape;

    logic [DEPTH-1:0] w_shifted;
    logic [DEPTH-1:0] w_stepped;
    logic [DEPTH-1:0] w_afterKill;
    logic [DEPTH-1:0] w_next;
    logic             w_escape;
    logic             w_accept;

    // Shift one cell toward the exit; the entry cell is refilled with 0.
    generate
        if (DIR_UP == SI_DIR_UP) begin : g_shiftUp
            assign w_shifted = {r_track[DEPTH-2:0], 1'b0};
        end else begin : g_shiftDown
            assign w_shifted = {1'b0, r_track[DEPTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_stepped   = r_track;
        w_escape    = 1'b0;
        if (i_tick) begin
            w_stepped = w_shifted;
            // Escape is taken from the pre-shift exit cell, so a kill aimed
            // at that bullet in the same cycle cannot cancel it.
            w_escape  = r_track[c_EXIT];
        end

        w_afterKill = w_stepped & ~i_kill;

        // Fire is evaluated after kill: a kill on the entry cell frees it for
        // a simultaneous fire. On a tick the entry cell is always vacant.
        w_accept    = i_fire & ~w_afterKill[c_ENTRY];

        w_next      = w_afterKill;
        if (w_accept) begin
            w_next[c_ENTRY] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_track   <= '0;
            r_fireAck <= 1'b0;
            r_escape  <= 1'b0;
        end else if (i_clear) begin
            r_track   <= '0;
            r_fireAck <= 1'b0;
            r_escape  <= 1'b0;
        end else begin
            r_track   <= w_next;
            r_fireAck <= w_accept;
            r_escape  <= w_escape;
        end
    end

    assign o_data    = r_track;
    assign o_fireAck = r_fireAck;
    assign o_escape  = r_escape;

endmodule : si_bullet_track
`default_nettype wire

// File: rtl/si_bullet_shifter_bank.sv
`default_nettype none
// ============================================================================
//  Module      : si_bullet_shifter_bank
//  Description : Bank of NUM_CH independent bullet tracks of DEPTH cells for
//                the Space Invaders playfield. A shared prescaler produces a
//                shift tick every TICK_DIV enabled cycles; clear resets every
//                track and the prescaler together.
//  Ports       : SC_BulletBank_CLOCK_50     - system clock, rising edge
//                SC_BulletBank_RESET_InHigh - asynchronous active-high reset
//                SC_BulletBank_enable_In    - prescaler run enable
//                SC_BulletBank_clear_In     - synchronous clear of bank
//                SC_BulletBank_fire_In      - per-channel fire request
//                SC_BulletBank_kill_In      - per-cell kill mask,
//                                             channel c = [c*DEPTH +: DEPTH]
//                SC_BulletBank_data_OutBus  - track contents, same packing
//                SC_BulletBank_tick_Out     - shift applied at next edge
//                SC_BulletBank_fire_ack_Out - per-channel accepted-fire pulse
//                SC_BulletBank_escape_Out   - per-channel escape pulse
//  Revision    : 1.0  - initial release
// ============================================================================
module si_bullet_shifter_bank
    import si_bullet_pkg::*;
#(
    parameter int   DEPTH    = 8,
    parameter int   NUM_CH   = 4,
    parameter int   TICK_DIV = 4,
    parameter logic DIR_UP   = SI_DIR_UP
)
(
    input  logic                    SC_BulletBank_CLOCK_50,
    input  logic                    SC_BulletBank_RESET_InHigh,
    input  logic                    SC_BulletBank_enable_In,
    input  logic                    SC_BulletBank_clear_In,
    input  logic [NUM_CH-1:0]       SC_BulletBank_fire_In,
    input  logic [NUM_CH*DEPTH-1:0] SC_BulletBank_kill_In,
    output logic [NUM_CH*DEPTH-1:0] SC_BulletBank_data_OutBus,
    output logic                    SC_BulletBank_tick_Out,
    output logic [NUM_CH-1:0]       SC_BulletBank_fire_ack_Out,
    output logic [NUM_CH-1:0]       SC_BulletBank_escape_Out
);

    localparam int                 c_CNT_W   = siCntWidth(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tick;

    // ------------------------------------------------------------------
    // Shared prescaler: counts enabled cycles, ticks on the last one.
    // ------------------------------------------------------------------
    assign w_tick = SC_BulletBank_enable_In & (r_cnt == c_CNT_MAX);

    always_ff @(posedge SC_BulletBank_CLOCK_50 or posedge SC_BulletBank_RESET_InHigh) begin
        if (SC_BulletBank_RESET_InHigh) begin
            r_cnt <= '0;
        end else if (SC_BulletBank_clear_In) begin
            r_cnt <= '0;
        end else if (SC_BulletBank_enable_In) begin
            r_cnt <= w_tick ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

    // With TICK_DIV = 1 the reset counter value already matches the compare,
    // so the exported tick is masked while reset is asserted.
    assign SC_BulletBank_tick_Out = w_tick & ~SC_BulletBank_RESET_InHigh;

    // ------------------------------------------------------------------
    // Track channels, sharing only tick and clear.
    // ------------------------------------------------------------------
    generate
        for (genvar gCh = 0; gCh < NUM_CH; gCh++) begin : g_ch
            si_bullet_track #(
                .DEPTH  (DEPTH),
                .DIR_UP (DIR_UP)
            ) u_track (
                .clk       (SC_BulletBank_CLOCK_50),
                .rst       (SC_BulletBank_RESET_InHigh),
                .i_clear   (SC_BulletBank_clear_In),
                .i_tick    (w_tick),
                .i_fire    (SC_BulletBank_fire_In[gCh]),
                .i_kill    (SC_BulletBank_kill_In[gCh*DEPTH +: DEPTH]),
                .o_data    (SC_BulletBank_data_OutBus[gCh*DEPTH +: DEPTH]),
                .o_fireAck (SC_BulletBank_fire_ack_Out[gCh]),
                .o_escape  (SC_BulletBank_escape_Out[gCh])
            );
        end
    endgenerate

endmodule : si_bullet_shifter_bank
`default_nettype wire
